// File: rtl/taylor_stage_control.sv
`default_nettype none
// ============================================================================
// Module   : taylor_stage_control
// Brief    : Horner-iteration sequencer for the exponential unit Taylor stage.
//            Walks N_TERMS multiply/add steps with optional multiplier wait.
// Revision : 1.0 - initial release
// ============================================================================
module taylor_stage_control #(
  parameter int N_TERMS = 4,
  parameter int MUL_LAT = 1,
  parameter int IDX_W   = 3
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             mul_ss,
  output logic             mul_ss_en,
  output logic             add_ss,
  output logic             add_ss_en,
  output logic [IDX_W-1:0] coef_idx,
  output logic             output_ready
);

  localparam int               c_cnt_w     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(N_TERMS - 1);
  localparam logic [c_cnt_w-1:0] c_wait_init = c_cnt_w'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ADD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;

  state_t             w_next_state;
  logic [IDX_W-1:0]   w_next_idx;
  logic [c_cnt_w-1:0] w_next_cnt;

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = coef_idx;
    w_next_cnt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_MUL;
          w_next_idx   = c_last_idx;
        end
      end
      ST_MUL: begin
        if (MUL_LAT == 1) begin
          w_next_state = ST_ADD;
        end else begin
          w_next_state = ST_WAIT;
          w_next_cnt   = c_wait_init;
        end
      end
      ST_WAIT: begin
        w_next_cnt = r_cnt - c_cnt_w'(1);
        if (r_cnt == c_cnt_w'(1)) begin
          w_next_state = ST_ADD;
        end
      end
      ST_ADD: begin
        if (coef_idx == '0) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_MUL;
          w_next_idx   = coef_idx - IDX_W'(1);
        end
      end
      ST_DONE: begin
        w_next_idx = '0;
        if (start) begin
          w_next_state = ST_MUL;
          w_next_idx   = c_last_idx;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_idx   = '0;
        w_next_cnt   = '0;
      end
    endcase
    // Cancel wins over everything, including a start seen in IDLE/DONE.
    if (abort) begin
      w_next_state = ST_IDLE;
      w_next_idx   = '0;
      w_next_cnt   = '0;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      coef_idx     <= '0;
      busy         <= 1'b0;
      mul_ss       <= 1'b0;
      mul_ss_en    <= 1'b0;
      add_ss       <= 1'b0;
      add_ss_en    <= 1'b0;
      output_ready <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      coef_idx     <= w_next_idx;
      busy         <= (w_next_state == ST_MUL) || (w_next_state == ST_WAIT) ||
                      (w_next_state == ST_ADD);
      mul_ss_en    <= (w_next_state == ST_MUL);
      mul_ss       <= (w_next_state == ST_MUL) && (w_next_idx == c_last_idx);
      add_ss_en    <= (w_next_state == ST_ADD);
      add_ss       <= (w_next_state == ST_ADD) && (w_next_idx == '0);
      output_ready <= (w_next_state == ST_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_taylor_stage_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_taylor_stage_control
// Brief    : Scoreboard bench for three taylor_stage_control configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_taylor_stage_control;

  typedef logic [8:0] vec_t;  // {busy,mul_ss,mul_ss_en,add_ss,add_ss_en,output_ready,coef_idx}
  typedef struct packed {
    vec_t e2;
    vec_t e1;
    vec_t e0;
  } exp_t;

  logic       clk = 1'b0;
  logic [2:0] rstn_v;
  logic [2:0] start_v;
  logic [2:0] abort_v;
  logic [2:0] busy_v, mss_v, msen_v, ass_v, asen_v, ordy_v;
  logic [2:0] idx0, idx1, idx2;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  taylor_stage_control #(.N_TERMS(4), .MUL_LAT(1), .IDX_W(3)) u_dut0 (
    .CLK(clk), .rst_n(rstn_v[0]), .start(start_v[0]), .abort(abort_v[0]),
    .busy(busy_v[0]), .mul_ss(mss_v[0]), .mul_ss_en(msen_v[0]), .add_ss(ass_v[0]),
    .add_ss_en(asen_v[0]), .coef_idx(idx0), .output_ready(ordy_v[0]));

  taylor_stage_control #(.N_TERMS(4), .MUL_LAT(3), .IDX_W(3)) u_dut1 (
    .CLK(clk), .rst_n(rstn_v[1]), .start(start_v[1]), .abort(abort_v[1]),
    .busy(busy_v[1]), .mul_ss(mss_v[1]), .mul_ss_en(msen_v[1]), .add_ss(ass_v[1]),
    .add_ss_en(asen_v[1]), .coef_idx(idx1), .output_ready(ordy_v[1]));

  taylor_stage_control #(.N_TERMS(1), .MUL_LAT(1), .IDX_W(3)) u_dut2 (
    .CLK(clk), .rst_n(rstn_v[2]), .start(start_v[2]), .abort(abort_v[2]),
    .busy(busy_v[2]), .mul_ss(mss_v[2]), .mul_ss_en(msen_v[2]), .add_ss(ass_v[2]),
    .add_ss_en(asen_v[2]), .coef_idx(idx2), .output_ready(ordy_v[2]));

  function automatic vec_t get_act(int d);
    logic [2:0] idx;
    idx = (d == 0) ? idx0 : (d == 1) ? idx1 : idx2;
    return {busy_v[d], mss_v[d], msen_v[d], ass_v[d], asen_v[d], ordy_v[d], idx};
  endfunction

  function automatic vec_t v_mul(int k, bit first);
    return {1'b1, first, 1'b1, 1'b0, 1'b0, 1'b0, 3'(k)};
  endfunction
  function automatic vec_t v_wait(int k);
    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'(k)};
  endfunction
  function automatic vec_t v_add(int k, bit last);
    return {1'b1, 1'b0, 1'b0, last, 1'b1, 1'b0, 3'(k)};
  endfunction
  function automatic vec_t v_done();
    return 9'b0_0000_1_000;
  endfunction

  task automatic check(int d, vec_t exp_v, string tag);
    vec_t a;
    a = get_act(d);
    n_checks++;
    if (a === exp_v) n_pass++;
    else $display("FAIL %s dut%0d at %0t: got %b expected %b", tag, d, $time, a, exp_v);
  endtask

  // Monitor: one expected triple per sampled cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(0, e.e0, "trace");
      check(1, e.e1, "trace");
      check(2, e.e2, "trace");
    end
  end

  // Queue the expectation for dut d after the coming edge; others stay idle.
  task automatic tick(int d, vec_t v);
    exp_t e;
    e = '0;
    case (d)
      0:       e.e0 = v;
      1:       e.e1 = v;
      default: e.e2 = v;
    endcase
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_eval(int d, int n, int l, bit keep_start);
    start_v[d] = 1'b1;
    for (int k = n - 1; k >= 0; k--) begin
      tick(d, v_mul(k, k == n - 1));
      if (!keep_start) start_v[d] = 1'b0;
      for (int w = 1; w < l; w++) tick(d, v_wait(k));
      tick(d, v_add(k, k == 0));
    end
    tick(d, v_done());
  endtask

  initial begin
    rstn_v  = 3'b000;
    start_v = 3'b000;
    abort_v = 3'b000;
    tick(0, '0);
    tick(0, '0);
    rstn_v = 3'b111;
    tick(0, '0);
    tick(0, '0);

    // Single evaluation, N=4 L=1
    run_eval(0, 4, 1, 1'b0);
    tick(0, '0);
    tick(0, '0);

    // Start held high: DONE chains straight into the next MUL
    run_eval(0, 4, 1, 1'b1);
    run_eval(0, 4, 1, 1'b1);
    run_eval(0, 4, 1, 1'b0);
    tick(0, '0);

    // Abort mid-run, then a clean evaluation
    start_v[0] = 1'b1;
    tick(0, v_mul(3, 1'b1));
    start_v[0] = 1'b0;
    tick(0, v_add(3, 1'b0));
    tick(0, v_mul(2, 1'b0));
    tick(0, v_add(2, 1'b0));
    tick(0, v_mul(1, 1'b0));
    abort_v[0] = 1'b1;
    tick(0, '0);
    abort_v[0] = 1'b0;
    tick(0, '0);
    run_eval(0, 4, 1, 1'b0);
    // Abort beats start while in DONE
    abort_v[0] = 1'b1;
    start_v[0] = 1'b1;
    tick(0, '0);
    abort_v[0] = 1'b0;
    start_v[0] = 1'b0;
    tick(0, '0);

    // N=4 L=3 with wait cycles
    run_eval(1, 4, 3, 1'b0);
    tick(1, '0);

    // Asynchronous reset in the middle of WAIT
    start_v[1] = 1'b1;
    tick(1, v_mul(3, 1'b1));
    start_v[1] = 1'b0;
    tick(1, v_wait(3));
    #1 rstn_v[1] = 1'b0;
    #1 check(1, '0, "async_reset");
    tick(1, '0);
    tick(1, '0);
    rstn_v[1] = 1'b1;
    tick(1, '0);
    tick(1, '0);
    tick(1, '0);
    run_eval(1, 4, 3, 1'b0);
    tick(1, '0);

    // Single-term configuration
    run_eval(2, 1, 1, 1'b0);
    tick(2, '0);
    tick(2, '0);

    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/taylor_stage_control.md
Name: taylor_stage_control

Overview:
Parametrised sequencer for the Taylor-series datapath of the exponential unit. It generalises the fixed 4-state stage-2 controller to N Horner iterations: acc = c[N-1]*x + ...; for k from N-1 down to 0, acc = acc*x + c[k]. It issues multiplier and adder select/enable strobes and a coefficient ROM index. It also waits out a configurable multiplier latency and signals completion with a one-cycle output_ready pulse.

Parameters:
N_TERMS, 4, number of Horner multiply/add iterations (>=1)
MUL_LAT, 1, multiplier latency in cycles (>=1); adds MUL_LAT-1 wait cycles per iteration
IDX_W, 3, width of coef_idx; must satisfy 2^IDX_W >= N_TERMS

Ports:
CLK  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin evaluation; sampled in IDLE or DONE only
abort  in  1  synchronous cancel; priority over start
busy  out  1  high in MUL, WAIT and ADD states
mul_ss  out  1  multiplier operand select: 1 = seed operand (first iteration), 0 = accumulator
mul_ss_en  out  1  multiplier load strobe
add_ss  out  1  adder select: 1 = final add (result to output register), 0 = write back to accumulator
add_ss_en  out  1  adder load strobe
coef_idx  out  IDX_W  coefficient ROM address for the current iteration
output_ready  out  1  one-cycle pulse; result valid

Behaviour:
- States: IDLE, MUL, WAIT, ADD, DONE. Moore outputs are decoded from state, coef_idx and the wait counter.
- Reset (rst_n=0, asynchronous): state=IDLE, coef_idx=0, wait counter=0. All outputs are 0 while in reset and in IDLE. Unlike stage 2, IDLE asserts no strobes.
- IDLE:
  - start=1 and abort=0 -> MUL; coef_idx loaded with N_TERMS-1.
  - Otherwise remain in IDLE.
- MUL (1 cycle):
  - mul_ss_en=1; mul_ss=1 iff coef_idx==N_TERMS-1; busy=1.
  - MUL_LAT==1 -> ADD.
  - Otherwise -> WAIT, with the wait counter loaded to MUL_LAT-1.
- WAIT (MUL_LAT-1 cycles):
  - All strobes 0; busy=1; the counter decrements each cycle.
  - Counter==1 -> ADD.
- ADD (1 cycle):
  - add_ss_en=1; add_ss=1 iff coef_idx==0; busy=1.
  - coef_idx==0 -> DONE.
  - Otherwise coef_idx decrements and the next state is MUL.
- DONE (1 cycle):
  - output_ready=1; busy=0; coef_idx=0.
  - start=1 -> MUL (back-to-back evaluation, coef_idx reloaded).
  - Otherwise -> IDLE.
- start asserted in MUL, WAIT or ADD is ignored. There is no queuing.
- abort=1 in any state -> IDLE next edge, coef_idx=0. No output_ready is produced. Abort sampled in DONE still lets that DONE cycle's output_ready be seen, because the outputs are Moore.
- Latency: output_ready is high in the cycle following edge N_TERMS*(MUL_LAT+1) after the edge that samples start. Each iteration takes exactly MUL_LAT+1 cycles.
- Per evaluation: exactly N_TERMS mul_ss_en pulses, N_TERMS add_ss_en pulses, one mul_ss=1 (first MUL), one add_ss=1 (last ADD).
- mul_ss_en and add_ss_en are never high in the same cycle.
- An asynchronous rst_n assertion mid-operation forces IDLE immediately; the outputs drop without waiting for a clock edge.
- N_TERMS=1: a single MUL has mul_ss=1 and the single ADD has add_ss=1.

Test Plan:
- N_TERMS=4, MUL_LAT=1, start pulse at edge 0:
  - states MUL,ADD x4 then DONE; output_ready high after edge 8;
  - coef_idx sequence 3,3,2,2,1,1,0,0;
  - mul_ss=1 only in the first cycle; add_ss=1 only in the last ADD.
- N_TERMS=4, MUL_LAT=3:
  - each MUL is followed by 2 WAIT cycles with no strobes;
  - output_ready after edge 16; busy high for 16 cycles.
- Back-to-back: start held high continuously with N=4, L=1 -> output_ready pulses every 9 cycles. start during busy has no effect.
- abort at cycle 5 of an N=4, L=1 run -> IDLE next edge; coef_idx=0; no output_ready. A new start then completes normally with latency 8.
- rst_n pulled low asynchronously mid-WAIT -> all outputs 0 before the next edge. After release, IDLE holds until start.
- N_TERMS=1, MUL_LAT=1 -> MUL with mul_ss=1, then ADD with add_ss=1, then output_ready after edge 2.
